// File: rtl/i2c_pkg.sv
// Shared constants for the I2C bus monitor: idle level, default timing
// parameters and counter widths sized for the legal parameter ranges.
package i2c_pkg;

  localparam logic I2C_IDLE_LEVEL      = 1'b1;
  localparam int   DEF_FILTER_LEN      = 4;
  localparam int   DEF_IDLE_CYCLES     = 1000;
  localparam int   FILTER_LEN_MAX      = 255;
  localparam int   IDLE_CYCLES_MAX     = 65535;
  localparam int   FILT_CNT_W          = $clog2(FILTER_LEN_MAX + 1);
  localparam int   IDLE_CNT_W          = $clog2(IDLE_CYCLES_MAX + 1);

endpackage

// File: rtl/i2c_glitch_filter.sv
// Single-line glitch filter: the filtered level follows the raw line only after
// FILTER_LEN consecutive differing cycles; edge pulses lag the update by one cycle.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic filt_out,
  output logic rise,
  output logic fall
);

  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILTER_LEN - 1);

  logic [FILT_CNT_W-1:0] r_cnt;
  logic                  r_filt;
  logic                  r_prev;
  logic                  r_rise;
  logic                  r_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_filt <= I2C_IDLE_LEVEL;
      r_prev <= I2C_IDLE_LEVEL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      if (raw_in != r_filt) begin
        if (r_cnt == CNT_LAST) begin
          r_filt <= raw_in;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
      // r_prev holds the level from before the last update, so pulses land one cycle after filt moves
      r_prev <= r_filt;
      r_rise <= r_filt & ~r_prev;
      r_fall <= ~r_filt & r_prev;
    end
  end

  assign filt_out = r_filt;
  assign rise     = r_rise;
  assign fall     = r_fall;

endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: filters SCL/SDA, emits SCL edge and START/STOP pulses,
// and tracks bus-busy with an optional idle timeout.
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_filt,
  output logic sda_filt,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic idle_timeout
);

  localparam logic [IDLE_CNT_W-1:0] IDLE_LAST =
    IDLE_CNT_W'((IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1);

  logic w_scl_filt, w_sda_filt;
  logic w_scl_rise, w_scl_fall;
  logic w_sda_rise, w_sda_fall;
  logic w_unused_sda_edges;
  logic w_start, w_stop, w_idle_cond, w_timeout;

  logic                  r_scl_prev;
  logic                  r_sda_prev;
  logic                  r_start;
  logic                  r_stop;
  logic                  r_busy;
  logic                  r_timeout;
  logic [IDLE_CNT_W-1:0] r_idle_cnt;

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (scl_in),
    .filt_out (w_scl_filt),
    .rise     (w_scl_rise),
    .fall     (w_scl_fall)
  );

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (sda_in),
    .filt_out (w_sda_filt),
    .rise     (w_sda_rise),
    .fall     (w_sda_fall)
  );

  assign w_unused_sda_edges = w_sda_rise | w_sda_fall;

  // SCL must be stable high across the SDA transition; a simultaneous SCL edge disqualifies it
  assign w_start     = r_sda_prev & ~w_sda_filt & r_scl_prev & w_scl_filt;
  assign w_stop      = ~r_sda_prev & w_sda_filt & r_scl_prev & w_scl_filt;
  assign w_idle_cond = w_scl_filt & w_sda_filt & r_busy;
  assign w_timeout   = (IDLE_CYCLES != 0) && w_idle_cond && (r_idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_prev <= I2C_IDLE_LEVEL;
      r_sda_prev <= I2C_IDLE_LEVEL;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_scl_prev <= w_scl_filt;
      r_sda_prev <= w_sda_filt;
      r_start    <= w_start;
      r_stop     <= w_stop;
      r_timeout  <= w_timeout;
      if (w_start) begin
        r_busy <= 1'b1;
      end else if (w_stop || w_timeout) begin
        r_busy <= 1'b0;
      end
      if ((IDLE_CYCLES == 0) || !w_idle_cond) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt != '1) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

  assign scl_filt     = w_scl_filt;
  assign sda_filt     = w_sda_filt;
  assign scl_rise     = w_scl_rise;
  assign scl_fall     = w_scl_fall;
  assign start_det    = r_start;
  assign stop_det     = r_stop;
  assign bus_busy     = r_busy;
  assign idle_timeout = r_timeout;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: expected pulses are queued with their
// due cycle when stimulus is driven and matched as the DUT emits them.
module tb_i2c_bus_monitor;

  localparam int FLEN = 4;
  localparam int IDLE = 16;
  localparam int LAT  = FLEN + 1;

  localparam logic [4:0] EV_RISE  = 5'b10000;
  localparam logic [4:0] EV_FALL  = 5'b01000;
  localparam logic [4:0] EV_START = 5'b00100;
  localparam logic [4:0] EV_STOP  = 5'b00010;
  localparam logic [4:0] EV_TMO   = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic scl_in, sda_in;
  logic scl_filt, sda_filt, scl_rise, scl_fall;
  logic start_det, stop_det, bus_busy, idle_timeout;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  logic [4:0] mon_obs;
  exp_t       mon_exp;

  i2c_bus_monitor #(.FILTER_LEN(FLEN), .IDLE_CYCLES(IDLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .scl_in       (scl_in),
    .sda_in       (sda_in),
    .scl_filt     (scl_filt),
    .sda_filt     (sda_filt),
    .scl_rise     (scl_rise),
    .scl_fall     (scl_fall),
    .start_det    (start_det),
    .stop_det     (stop_det),
    .bus_busy     (bus_busy),
    .idle_timeout (idle_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int offset, input logic [4:0] ev);
    exp_t e;
    e.cyc = cyc + offset;
    e.ev  = ev;
    exp_q.push_back(e);
  endtask

  task automatic set_lines(input logic s, input logic d, input logic [4:0] ev);
    scl_in = s;
    sda_in = d;
    if (ev != 5'b0) expect_ev(LAT, ev);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every pulse the DUT emits must match the head of the expectation queue
  always @(negedge clk) begin
    if (!rst) begin
      mon_obs = {scl_rise, scl_fall, start_det, stop_det, idle_timeout};
      if (mon_obs != 5'b0) begin
        if (exp_q.size() == 0) begin
          mon_exp.cyc = -1;
          mon_exp.ev  = 5'b0;
        end else begin
          mon_exp = exp_q.pop_front();
        end
        check("event", 32'(mon_obs), 32'(mon_exp.ev));
        check("event_cycle", cyc, mon_exp.cyc);
        $display("event cyc=%0d obs=%05b exp=%05b@%0d", cyc, mon_obs, mon_exp.ev, mon_exp.cyc);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    scl_in = 1'b0;
    sda_in = 1'b0;
    wait_cyc(3);
    check("rst_scl_filt", scl_filt, 1'b1);
    check("rst_sda_filt", sda_filt, 1'b1);
    check("rst_busy", bus_busy, 1'b0);
    check("rst_pulses", {scl_rise, scl_fall, start_det, stop_det, idle_timeout}, 5'b0);

    // 1: post-reset synchronizer lows must never reach the filtered lines
    rst = 1'b0;
    wait_cyc(2);
    set_lines(1'b1, 1'b1, 5'b0);
    wait_cyc(50);
    check("t1_scl_filt", scl_filt, 1'b1);
    check("t1_sda_filt", sda_filt, 1'b1);
    check("t1_busy", bus_busy, 1'b0);

    // 2: 3-cycle glitch is rejected, 4-cycle low is accepted
    set_lines(1'b0, 1'b1, 5'b0);
    wait_cyc(3);
    set_lines(1'b1, 1'b1, 5'b0);
    wait_cyc(10);
    check("t2_glitch_filt", scl_filt, 1'b1);
    set_lines(1'b0, 1'b1, EV_FALL);
    wait_cyc(4);
    set_lines(1'b1, 1'b1, EV_RISE);
    check("t2_low_filt", scl_filt, 1'b0);
    wait_cyc(10);
    check("t2_high_filt", scl_filt, 1'b1);

    // 3: START then STOP
    set_lines(1'b1, 1'b0, EV_START);
    wait_cyc(LAT - 1);
    check("t3_busy_before", bus_busy, 1'b0);
    wait_cyc(1);
    check("t3_busy_set", bus_busy, 1'b1);
    wait_cyc(5);
    set_lines(1'b1, 1'b1, EV_STOP);
    wait_cyc(LAT - 1);
    check("t3_busy_hold", bus_busy, 1'b1);
    wait_cyc(1);
    check("t3_busy_clr", bus_busy, 1'b0);
    wait_cyc(5);

    // 4: repeated START while busy
    set_lines(1'b1, 1'b0, EV_START);
    wait_cyc(6);
    set_lines(1'b0, 1'b0, EV_FALL);
    wait_cyc(6);
    set_lines(1'b0, 1'b1, 5'b0);
    wait_cyc(6);
    set_lines(1'b1, 1'b1, EV_RISE);
    wait_cyc(6);
    set_lines(1'b1, 1'b0, EV_START);
    wait_cyc(6);
    check("t4_busy_rstart", bus_busy, 1'b1);

    // 5: simultaneous SCL/SDA rise gives only scl_rise, then idle timeout
    set_lines(1'b0, 1'b0, EV_FALL);
    wait_cyc(6);
    set_lines(1'b1, 1'b1, EV_RISE);
    expect_ev(FLEN + IDLE, EV_TMO);
    wait_cyc(FLEN + IDLE - 1);
    check("t5_busy_pre_tmo", bus_busy, 1'b1);
    wait_cyc(1);
    check("t5_busy_tmo", bus_busy, 1'b0);
    wait_cyc(5);

    // 6: asynchronous reset mid-byte
    set_lines(1'b1, 1'b0, EV_START);
    wait_cyc(6);
    set_lines(1'b0, 1'b0, EV_FALL);
    wait_cyc(6);
    set_lines(1'b0, 1'b1, 5'b0);
    wait_cyc(2);
    check("t6_busy_pre", bus_busy, 1'b1);
    check("t6_scl_pre", scl_filt, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_busy_async", bus_busy, 1'b0);
    check("t6_scl_async", scl_filt, 1'b1);
    check("t6_sda_async", sda_filt, 1'b1);
    wait_cyc(1);
    set_lines(1'b1, 1'b1, 5'b0);
    rst = 1'b0;
    wait_cyc(20);
    check("t6_busy_after", bus_busy, 1'b0);

    check("pending_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_bus_monitor.md
Name: i2c_bus_monitor

Overview:
Sits directly downstream of the two-flop SCL/SDA synchronizers in the I2C register block. Removes short glitches from the synchronized lines and produces the filtered bus levels. Emits one-cycle event pulses for SCL edges and START/STOP conditions, and tracks bus-busy state. Consumers are the I2C master/slave FSMs and the status register.

Parameters:
FILTER_LEN, 4, consecutive clk cycles a raw line must differ from its filtered value before the filtered value follows; legal range 3..255.
IDLE_CYCLES, 1000, cycles with both filtered lines high that force busy clear; 0 disables the timeout; legal max 2^16-1.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
scl_in  input  1  synchronized SCL (synchronizer output; reads 0 for 2 cycles after reset)
sda_in  input  1  synchronized SDA (same property)
scl_filt  output  1  glitch-filtered SCL level
sda_filt  output  1  glitch-filtered SDA level
scl_rise  output  1  one-cycle pulse on filtered SCL 0->1
scl_fall  output  1  one-cycle pulse on filtered SCL 1->0
start_det  output  1  one-cycle pulse on START or repeated START
stop_det  output  1  one-cycle pulse on STOP
bus_busy  output  1  level: high between START and STOP/timeout
idle_timeout  output  1  one-cycle pulse when the timeout clears busy

Behaviour:
- One clock, clk. rst is asynchronous and active-high. All outputs are registered.
- Reset values: scl_filt=1, sda_filt=1 (idle bus). All pulses=0, bus_busy=0, filter counters=0, idle counter=0.
- Filter (per line):
  - Counter increments each cycle raw != filt; resets to 0 on any cycle raw == filt.
  - When raw != filt and counter == FILTER_LEN-1, filt <= raw and counter <= 0.
  - A raw change held exactly FILTER_LEN cycles updates filt at the FILTER_LEN-th edge. A shorter excursion is discarded.
  - FILTER_LEN >= 3 guarantees the 2-cycle post-reset low from the synchronizers never reaches filt.
- Event pulses:
  - Asserted in the cycle after filt changes, so raw-to-pulse latency is FILTER_LEN+1 cycles.
  - Each pulse is high for exactly 1 cycle.
- START: sda_filt 1->0 while scl_filt is 1 in both the previous and current cycle.
- STOP: sda_filt 0->1 under the same SCL qualification.
- Simultaneous filtered SCL and SDA transition in the same cycle: SCL edge pulse only; no START/STOP.
- bus_busy:
  - Set by START; stays 1 on repeated START.
  - Cleared by STOP, or by idle timeout.
  - STOP while not busy still pulses stop_det; busy stays 0.
- Idle counter:
  - Counts while scl_filt & sda_filt & bus_busy; resets otherwise; saturates.
  - When it reaches IDLE_CYCLES, pulse idle_timeout and clear bus_busy in the same cycle.
  - IDLE_CYCLES=0: counter inactive, idle_timeout never asserts.
- A START and the timeout cannot coincide, because START requires SDA low.
- rst mid-transaction: everything returns immediately to reset values, with no pulses generated.

Decomposition:
- Shared package i2c_pkg holds:
  - I2C_IDLE_LEVEL = 1'b1
  - default FILTER_LEN and IDLE_CYCLES constants
  - localparam widths for filter and idle counters, derived with $clog2
- One sub-module, i2c_glitch_filter (params FILTER_LEN; ports clk, rst, raw_in, filt_out, rise, fall), instantiated once for SCL and once for SDA.
- START/STOP/busy/timeout logic lives in the top.

Test Plan:
Use FILTER_LEN=4, IDLE_CYCLES=16 throughout.
1. Release rst; scl_in/sda_in held 0 for 2 cycles then 1 -> scl_filt/sda_filt stay 1, no pulses, bus_busy=0 for 50 cycles.
2. SCL high; scl_in low for 3 cycles then high -> no scl_fall. Same with 4 cycles low -> scl_fall pulse 5 cycles after first low cycle, then scl_rise 5 cycles after return high.
3. SCL high, sda_in 1->0 held -> start_det pulse at +5 cycles, bus_busy=1. Later sda_in 0->1 with SCL high -> stop_det pulse at +5, bus_busy=0 the same cycle.
4. While busy: SCL low, SDA high, SCL high, then SDA low -> start_det pulses, bus_busy stays 1, no stop_det.
5. SCL and SDA low-to-high on the same cycle while busy, then held high -> scl_rise pulse, no stop_det; idle_timeout pulses 16 cycles after filters settle high and bus_busy drops to 0.
6. Assert rst for 1 cycle while busy mid-byte -> bus_busy=0 and filt=1 immediately, no start_det/stop_det following release.
